accel_stim_feeder: RTL
======================

# accel_stim_feeder

Parametrised, synthesizable stimulus source for `accelerator_core` and its wider variants. It serves data and weight requests on the core's request/valid handshake. It sequences weight reloads every programmable number of data words and stops after a programmable total. It runs both in simulation benches and on-board self-test, replacing fixed-geometry pattern generators.

## Interface
Parameters:
- BIT_WIDTH, 8, element width
- NUM_CHANNEL, 3, channels per data word
- NUM_KERNEL, 4, kernels per weight word
- REG_WIDTH, 32, config/status register width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_data_req  in  1  request one data word (from core o_data_req)
- o_data  out  BIT_WIDTH*NUM_CHANNEL  data word; lane c at [c*BIT_WIDTH +: BIT_WIDTH]
- o_data_val  out  1  data beat valid
- i_weight_req  in  1  request one weight word
- o_weight  out  BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL  weight word; lane k*NUM_CHANNEL+c
- o_weight_val  out  1  weight beat valid
- i_conf_ctrl  in  REG_WIDTH  bit0 run, bit1 pattern select (LFSR), others ignored
- i_conf_cnt  in  REG_WIDTH  total data words
- i_conf_weightinterval  in  REG_WIDTH  data words between weight reloads; 0 = load once
- i_conf_kernelsize  in  REG_WIDTH  K; weight burst = K*K beats; 0 treated as 1
- o_busy  out  1  state not IDLE/DONE
- o_done  out  1  state DONE
- o_data_cnt  out  REG_WIDTH  data words issued since start

## Operation
- States: IDLE, WLOAD, STREAM, DONE.
- IDLE: on run=1 -> WLOAD. If i_conf_cnt=0, go -> DONE instead. Config is latched at this transition. Counters and LFSRs are cleared or seeded here.
- WLOAD: each i_weight_req high produces one weight beat. After the K*K-th beat -> STREAM. The interval counter clears.
- STREAM: each i_data_req high produces one data beat; o_data_cnt and the interval counter increment. Exit rules, checked on that beat:
  - o_data_cnt reaches cnt -> DONE. This has priority over the reload rule.
  - Otherwise, interval reaches a nonzero weightinterval -> WLOAD.
- DONE: o_done=1 and holds until run=0 -> IDLE.
- run=0 in any state -> IDLE next cycle. Pending valids are not issued after that cycle.
- Requests that arrive in a state where they are ineligible are dropped, not queued. Examples: data req in WLOAD, weight req in STREAM.
- Counter pattern:
  - data lane c = (word*NUM_CHANNEL + c) mod 2^BIT_WIDTH
  - weight lane i = (beat*NUM_CHANNEL*NUM_KERNEL + i + 1) mod 2^BIT_WIDTH
  - beat counts across all bursts since start.
- Counters are REG_WIDTH wide. K*K is computed at REG_WIDTH, and overflow is not checked.

## Timing
- A beat appears exactly 1 cycle after its request is sampled high. Back-to-back requests give one beat per cycle.
- Each valid is a one-cycle pulse per request. Output data is held until the next beat.
- The state change takes effect the cycle after the terminating beat's request. A request in that same cycle counts only if the old state accepts it.
- Reset values: o_data=0, o_weight=0, both valids 0, o_busy=0, o_done=0, o_data_cnt=0, state IDLE.
- Reset asserted mid-run returns to these values asynchronously. Operation restarts only on a fresh run=1 seen in IDLE.

## Configuration
- ACCEL_STIM_LFSR_EN defined:
  - bit1=1 selects LFSR pattern. Data and weight each use a 32-bit Galois LFSR (x^32+x^22+x^2+x+1), seeded 32'hACE10001 and 32'h5EED0002 on start.
  - The LFSR steps once per issued beat. Lane i = (lfsr[BIT_WIDTH-1:0] + i) mod 2^BIT_WIDTH.
- ACCEL_STIM_LFSR_EN undefined: bit1 is ignored, the counter pattern is always used, and no LFSR logic is instantiated.

## Structure
- Package accel_stim_pkg holds:
  - state encoding (IDLE=0, WLOAD=1, STREAM=2, DONE=3)
  - LFSR seeds and tap mask
  - ctrl bit indices
- Sub-module accel_stim_lfsr is instantiated twice (data and weight), with ports load, step, and 32-bit state.

## Test plan
All scenarios use defaults BIT_WIDTH=8, NUM_CHANNEL=3, NUM_KERNEL=4.
- K=3, cnt=6, interval=0, with data and weight req held high:
  - 9 weight beats; the first is lanes 1..12, the last lanes 97..108.
  - Then 6 data beats, 0x020100 through 0x11100F.
  - o_done=1; o_data_cnt=6.
- cnt=10, interval=4, K=1: weight/data beat order is W,D4,W,D4,W,D2. The third weight word's lane0 = 25.
- Toggle data req every other cycle in STREAM: each valid comes 1 cycle after its req. No beats are lost or duplicated.
- Data req only during WLOAD: no o_data_val. The later data stream still starts at word 0.
- run dropped mid-STREAM after 3 beats: IDLE next cycle, o_busy=0. Re-run restarts at o_data_cnt=0 and data 0x020100.
- Async rst pulse mid-WLOAD: all outputs are 0 within the same cycle. With ACCEL_STIM_LFSR_EN and bit1=1, the first data beat after re-run equals the seed-derived value 0x03 0x02 0x01 over lanes 2..0 (seed low byte 0x01).

Source files
------------

// File: rtl/accel_stim_pkg.sv
// Shared definitions for the accelerator stimulus feeder.
// Holds the FSM state encoding, LFSR seeds/taps and control-register bit positions.
// No logic; imported by the interface-level modules.
package accel_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WLOAD  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting)
  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] DATA_SEED   = 32'hACE1_0001;
  localparam logic [31:0] WEIGHT_SEED = 32'h5EED_0002;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_LFSR = 1;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/accel_stim_if.sv
// Request/valid bundle between the stimulus feeder (master) and the core (slave).
// Beats follow their request by one cycle; no stalls, the request itself is the flow control.
// Requests the feeder cannot serve in its current state are dropped, not queued.
interface accel_stim_if #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4
);
  logic                                        data_req;
  logic [BIT_WIDTH*NUM_CHANNEL-1:0]            data;
  logic                                        data_val;
  logic                                        weight_req;
  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] weight;
  logic                                        weight_val;

  modport master (
    input  data_req, weight_req,
    output data, data_val, weight, weight_val
  );

  modport slave (
    output data_req, weight_req,
    input  data, data_val, weight, weight_val
  );
endinterface

// File: rtl/accel_stim_lfsr.sv
// 32-bit Galois LFSR with synchronous reseed and a per-beat step enable.
// State updates one cycle after load/step; load wins over step.
// No backpressure: the owner decides when to step.
module accel_stim_lfsr
  import accel_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] state
);

  // Reseed on start, advance once per issued beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= SEED;
    else if (load) state <= SEED;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/accel_stim_feeder.sv
// Stimulus source: weight bursts of K*K beats interleaved with data words, stops after cnt words.
// Latency: each beat is registered and appears 1 cycle after its request is sampled.
// Backpressure: none; ineligible requests are dropped. Optional LFSR pattern: ACCEL_STIM_LFSR_EN.
module accel_stim_feeder
  import accel_stim_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int REG_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  accel_stim_if.master         bus,
  input  logic [REG_WIDTH-1:0] i_conf_ctrl,
  input  logic [REG_WIDTH-1:0] i_conf_cnt,
  input  logic [REG_WIDTH-1:0] i_conf_weightinterval,
  input  logic [REG_WIDTH-1:0] i_conf_kernelsize,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [REG_WIDTH-1:0] o_data_cnt
);

  localparam int DW = BIT_WIDTH * NUM_CHANNEL;
  localparam int NW = NUM_CHANNEL * NUM_KERNEL;
  localparam int WW = DW * NUM_KERNEL;

  state_t state, state_nxt;

  logic                 run, start, w_acc, d_acc, w_last, d_last, d_reload;
  logic [REG_WIDTH-1:0] k_eff, kk_calc;
  logic [REG_WIDTH-1:0] cnt_q, intv_q, kk_q;
  logic [REG_WIDTH-1:0] wbeat_q, wburst_q, intv_cnt_q, data_cnt_q;
  logic [DW-1:0]        data_q, data_pat;
  logic [WW-1:0]        weight_q, weight_pat;
  logic                 data_val_q, weight_val_q;
  logic                 unused_ctrl;

  assign run     = i_conf_ctrl[CTRL_RUN];
  assign k_eff   = (i_conf_kernelsize == '0) ? REG_WIDTH'(1) : i_conf_kernelsize;
  assign kk_calc = k_eff * k_eff;

  // A request only counts while run is high in the state that serves it
  assign start    = (state == ST_IDLE) && run;
  assign w_acc    = (state == ST_WLOAD) && run && bus.weight_req;
  assign d_acc    = (state == ST_STREAM) && run && bus.data_req;
  assign w_last   = (wburst_q + REG_WIDTH'(1)) == kk_q;
  assign d_last   = (data_cnt_q + REG_WIDTH'(1)) == cnt_q;
  assign d_reload = (intv_q != '0) && ((intv_cnt_q + REG_WIDTH'(1)) == intv_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: run low always wins; end-of-stream beats DONE before reload
  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = (i_conf_cnt == '0) ? ST_DONE : ST_WLOAD;
        ST_WLOAD:  if (w_acc && w_last) state_nxt = ST_STREAM;
        ST_STREAM: if (d_acc) begin
                     if (d_last)        state_nxt = ST_DONE;
                     else if (d_reload) state_nxt = ST_WLOAD;
                   end
        default:   state_nxt = state;
      endcase
    end
  end

  // Status decode
  always_comb begin
    o_busy = (state == ST_WLOAD) || (state == ST_STREAM);
    o_done = (state == ST_DONE);
  end

`ifdef ACCEL_STIM_LFSR_EN
  logic        lsel_q;
  logic [31:0] dl_state, wl_state;
  logic        unused_lfsr;

  accel_stim_lfsr #(.SEED(DATA_SEED)) u_data_lfsr (
    .clk(clk), .rst(rst), .load(start), .step(d_acc), .state(dl_state)
  );
  accel_stim_lfsr #(.SEED(WEIGHT_SEED)) u_weight_lfsr (
    .clk(clk), .rst(rst), .load(start), .step(w_acc), .state(wl_state)
  );
  assign unused_lfsr = ^{dl_state, wl_state};

  // Pattern select is latched with the rest of the config
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        lsel_q <= 1'b0;
    else if (start) lsel_q <= i_conf_ctrl[CTRL_LFSR];
  end
`endif

  assign unused_ctrl = ^i_conf_ctrl;

  // Lane patterns for the next beat: counter by default, LFSR offset when selected
  always_comb begin
    data_pat   = '0;
    weight_pat = '0;
    for (int c = 0; c < NUM_CHANNEL; c++)
      data_pat[c*BIT_WIDTH +: BIT_WIDTH] =
        BIT_WIDTH'(data_cnt_q * REG_WIDTH'(NUM_CHANNEL) + REG_WIDTH'(c));
    for (int i = 0; i < NW; i++)
      weight_pat[i*BIT_WIDTH +: BIT_WIDTH] =
        BIT_WIDTH'(wbeat_q * REG_WIDTH'(NW) + REG_WIDTH'(i + 1));
`ifdef ACCEL_STIM_LFSR_EN
    if (lsel_q) begin
      for (int c = 0; c < NUM_CHANNEL; c++)
        data_pat[c*BIT_WIDTH +: BIT_WIDTH] = dl_state[BIT_WIDTH-1:0] + BIT_WIDTH'(c);
      for (int i = 0; i < NW; i++)
        weight_pat[i*BIT_WIDTH +: BIT_WIDTH] = wl_state[BIT_WIDTH-1:0] + BIT_WIDTH'(i);
    end
`endif
  end

  // Datapath: config latch at start, beat registers, and the beat/interval counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      intv_q       <= '0;
      kk_q         <= '0;
      wbeat_q      <= '0;
      wburst_q     <= '0;
      intv_cnt_q   <= '0;
      data_cnt_q   <= '0;
      data_q       <= '0;
      weight_q     <= '0;
      data_val_q   <= 1'b0;
      weight_val_q <= 1'b0;
    end else begin
      data_val_q   <= d_acc;
      weight_val_q <= w_acc;
      if (start) begin
        cnt_q      <= i_conf_cnt;
        intv_q     <= i_conf_weightinterval;
        kk_q       <= kk_calc;
        wbeat_q    <= '0;
        wburst_q   <= '0;
        intv_cnt_q <= '0;
        data_cnt_q <= '0;
      end
      if (w_acc) begin
        weight_q <= weight_pat;
        wbeat_q  <= wbeat_q + REG_WIDTH'(1);
        wburst_q <= w_last ? '0 : wburst_q + REG_WIDTH'(1);
        if (w_last) intv_cnt_q <= '0;
      end
      if (d_acc) begin
        data_q     <= data_pat;
        data_cnt_q <= data_cnt_q + REG_WIDTH'(1);
        intv_cnt_q <= intv_cnt_q + REG_WIDTH'(1);
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_val   = data_val_q;
  assign bus.weight     = weight_q;
  assign bus.weight_val = weight_val_q;
  assign o_data_cnt     = data_cnt_q;

endmodule
